lsu_ctrl: RTL
=============

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter DM_ADDRESS, default 9: byte-address width of the data memory port.
REQ-002 Parameter DATA_W, default 32: data width; only 32 is supported.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  EX/MEM request present.
REQ-006 req_ready  out  1  block accepts request this cycle.
REQ-007 req_we  in  1  1=store, 0=load.
REQ-008 req_funct3  in  3  instr[14:12] access type.
REQ-009 req_addr  in  DM_ADDRESS  byte address (ALU result LSBs).
REQ-010 req_wdata  in  DATA_W  store data (rs2).
REQ-011 mem_re / mem_we  out  1 / 1  data-memory read / write strobes.
REQ-012 mem_addr  out  DM_ADDRESS  word-aligned address, bits [1:0]=0.
REQ-013 mem_be  out  4  byte-lane write enables.
REQ-014 mem_wdata  out  DATA_W  lane-aligned write data.
REQ-015 mem_rdata  in  DATA_W  word read data, valid in the same cycle as mem_re.
REQ-016 rsp_valid / rsp_ready  out / in  1 / 1  completion handshake towards MEM/WB.
REQ-017 rsp_rdata  out  DATA_W  extended load result; 0 for stores and errors.
REQ-018 rsp_err  out  1  unsupported funct3; no memory access performed.

Function
REQ-019 States: IDLE, ACC1, ACC2, RESP; req_ready = (state==IDLE).
REQ-020 IDLE: on req_valid, register the request; valid funct3 -> ACC1; invalid funct3 -> RESP with rsp_err=1.
REQ-021 Valid funct3 values: loads 000/001/010/100/101; stores 000/001/010; everything else is invalid.
REQ-022 off = addr[1:0]; size = 1/2/4 bytes from funct3[1:0]; the access is split iff off+size > 4.
REQ-023 ACC1: mem_addr = {addr[DM_ADDRESS-1:2],2'b00}; be1 = ((1<<size)-1)<<off, truncated to 4 bits; next state ACC2 if split, else RESP.
REQ-024 ACC2: mem_addr = first word + 4, wrapping modulo 2^DM_ADDRESS; be2 = ((1<<size)-1)>>(4-off); next state RESP.
REQ-025 Stores assert mem_we with mem_be = be1/be2 and mem_wdata = the 64-bit value {32'b0,wdata}<<(8*off), low half in ACC1, high half in ACC2.
REQ-026 Loads assert mem_re with mem_be = 0, and capture mem_rdata at the end of each ACC cycle.
REQ-027 Load result = ({w2,w1} >> 8*off) truncated to size, then extended: sign-extend for 000/001, zero-extend for 100/101.
REQ-028 Strobes are asserted only in ACC1/ACC2; mem_re and mem_we are never high together.
REQ-029 RESP: rsp_valid=1 and outputs held stable until rsp_ready; on rsp_valid&&rsp_ready -> IDLE.
REQ-030 A new request is accepted no earlier than the cycle after the response handshake; there is no bypass.
REQ-031 Latency from acceptance to rsp_valid: aligned 2 cycles, split 3 cycles, error 1 cycle.

Reset
REQ-032 While rst_n=0: state=IDLE, every strobe and mem_be = 0, rsp_valid=0, rsp_err=0, rsp_rdata=0, captured words = 0.
REQ-033 Reset asserted mid-access aborts the access immediately; no further strobes are issued and no response is produced.

Structure
REQ-034 lsu_pkg holds the state enum, the funct3 localparams (LB, LH, LW, LBU, LHU, SB, SH, SW) and the size/byte-enable helper function.
REQ-035 Sub-module lsu_lane_align is purely combinational: store shift and byte-enable generation, load shift and extension.

Verification
REQ-036 LW at 0x010, mem_rdata=0xDEADBEEF -> one read at 0x010; rsp_rdata=0xDEADBEEF 2 cycles after acceptance.
REQ-037 LB at 0x013, word=0x80000000 -> rsp_rdata=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-038 SH at 0x007, data 0x0000ABCD -> ACC1 mem_addr 0x004, be 1000, wdata 0xCD000000; ACC2 mem_addr 0x008, be 0001, wdata 0x000000AB.
REQ-039 LW at 0x1FE, words 0x11223344 @0x1FC and 0x55667788 @0x000 -> second access wraps to 0x000; rsp_rdata=0x77881122.
REQ-040 funct3=011 load -> no strobes; rsp_valid with rsp_err=1 and rdata=0 one cycle after acceptance.
REQ-041 rst_n dropped during ACC1 of a split SW, rsp_ready held low -> strobes low immediately, no ACC2 and no response; req_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 codes,
// and access-size / byte-mask helpers used by the controller and lane aligner.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Access size in bytes: 1, 2 or 4.
    function automatic logic [2:0] f3_size(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Contiguous byte mask of 'size' ones, i.e. (1<<size)-1.
    function automatic logic [7:0] size_mask(input logic [2:0] size);
        return (8'd1 << size) - 8'd1;
    endfunction

    function automatic logic f3_valid(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == SB) || (f3 == SH) || (f3 == SW);
        end
        return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Bundle of the request, data-memory and response signals of the LSU.
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// sender holds valid and its payload stable until that edge, ready may toggle freely.
interface lsu_ctrl_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;

    logic                  mem_re;
    logic                  mem_we;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, rsp_ready,
        output req_ready, mem_re, mem_we, mem_addr, mem_be, mem_wdata,
               rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, rsp_ready,
        input  req_ready, mem_re, mem_we, mem_addr, mem_be, mem_wdata,
               rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store data shift and byte enables for both
// words of a possibly split access, and load byte extraction plus extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] w1_i,
    input  logic [23:0] w2_i,
    output logic        split_o,
    output logic [3:0]  be1_o,
    output logic [3:0]  be2_o,
    output logic [31:0] st_lo_o,
    output logic [31:0] st_hi_o,
    output logic [31:0] ld_data_o
);

    logic [2:0]  size;
    logic [7:0]  mask;
    logic [63:0] st_wide;
    logic [31:0] ld_raw;

    always_comb begin
        size    = f3_size(funct3_i[1:0]);
        mask    = size_mask(size);
        split_o = (4'(off_i) + 4'(size)) > 4'd4;
        be1_o   = 4'(mask << off_i);
        be2_o   = 4'(mask >> (3'd4 - {1'b0, off_i}));

        st_wide = {32'b0, wdata_i} << {off_i, 3'b000};
        st_lo_o = st_wide[31:0];
        st_hi_o = st_wide[63:32];

        // Only the low three bytes of the second word can ever reach the result.
        case (off_i)
            2'd0:    ld_raw = w1_i;
            2'd1:    ld_raw = {w2_i[7:0],  w1_i[31:8]};
            2'd2:    ld_raw = {w2_i[15:0], w1_i[31:16]};
            default: ld_raw = {w2_i[23:0], w1_i[31:24]};
        endcase

        case (funct3_i)
            LB:      ld_data_o = {{24{ld_raw[7]}}, ld_raw[7:0]};
            LH:      ld_data_o = {{16{ld_raw[15]}}, ld_raw[15:0]};
            LBU:     ld_data_o = {24'b0, ld_raw[7:0]};
            LHU:     ld_data_o = {16'b0, ld_raw[15:0]};
            default: ld_data_o = ld_raw;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one request at a time, issues one or two
// word accesses to data memory, and returns the aligned/extended result.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_ctrl_if.slave  bus,
    output lsu_state_e state_o
);

    lsu_state_e            state_q, state_d;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [DM_ADDRESS-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  err_q;
    logic [31:0]           w1_q;
    logic [23:0]           w2_q;

    logic                  split;
    logic [3:0]            be1, be2;
    logic [31:0]           st_lo, st_hi, ld_data;
    logic [DM_ADDRESS-1:0] word_addr;
    logic                  accept;

    assign accept    = (state_q == IDLE) && bus.req_valid;
    assign word_addr = {addr_q[DM_ADDRESS-1:2], 2'b00};
    assign state_o   = state_q;

    lsu_lane_align u_align (
        .funct3_i  (f3_q),
        .off_i     (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .w1_i      (w1_q),
        .w2_i      (w2_q),
        .split_o   (split),
        .be1_o     (be1),
        .be2_o     (be2),
        .st_lo_o   (st_lo),
        .st_hi_o   (st_hi),
        .ld_data_o (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields are frozen at acceptance; read words land at the end of each ACC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            w1_q    <= '0;
            w2_q    <= '0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            err_q   <= !f3_valid(bus.req_we, bus.req_funct3);
            w1_q    <= '0;
            w2_q    <= '0;
        end else if ((state_q == ACC1) && !we_q) begin
            w1_q <= bus.mem_rdata;
        end else if ((state_q == ACC2) && !we_q) begin
            w2_q <= bus.mem_rdata[23:0];
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.req_ready = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_be    = 4'b0000;
        bus.mem_wdata = '0;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rsp_rdata = '0;

        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_d = f3_valid(bus.req_we, bus.req_funct3) ? ACC1 : RESP;
                end
            end
            ACC1: begin
                bus.mem_addr = word_addr;
                if (we_q) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_be    = be1;
                    bus.mem_wdata = st_lo;
                end else begin
                    bus.mem_re = 1'b1;
                end
                state_d = split ? ACC2 : RESP;
            end
            ACC2: begin
                // Second word wraps around the top of the data memory.
                bus.mem_addr = word_addr + DM_ADDRESS'(4);
                if (we_q) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_be    = be2;
                    bus.mem_wdata = st_hi;
                end else begin
                    bus.mem_re = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = err_q;
                bus.rsp_rdata = (we_q || err_q) ? '0 : ld_data;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
